dma_bus_initiator: RTL and testbench
====================================

// Module: dma_bus_initiator
// PURPOSE
//  Block-copy engine that acts as a second initiator on the MemoryUnit bus (address/data/we/start/busy/q).
//  The CPU programs four registers; the engine then moves LEN 32-bit words from SRC to DST,
//  one read then one write per word, and pulses an interrupt when the copy completes.
//  It sits beside the CPU in FPGC4; a top-level mux grants the bus via dma_req/dma_gnt.
// PARAMETERS
//  ADDR_W   27  bus word-address width (matches MemoryUnit address)
//  LEN_W    16  transfer-length counter width in words
// PORTS
//  clk         in   1       system clock (50 MHz), single clock domain
//  nreset      in   1       asynchronous, active-low reset
//  cfg_we      in   1       register write strobe from CPU side, one cycle
//  cfg_addr    in   2       0=SRC 1=DST 2=LEN 3=CTRL
//  cfg_d       in   32      register write data
//  cfg_q       out  32      read data for cfg_addr (combinational); CTRL reads {30'd0, active, done_sticky}
//  dma_req     out  1       bus request to arbiter
//  dma_gnt     in   1       bus grant from arbiter
//  address     out  ADDR_W  bus address
//  data        out  32      bus write data
//  we          out  1       bus write enable
//  start       out  1       single-cycle transaction start
//  busy        in   1       responder busy
//  q           in   32      responder read data
//  dma_irq     out  1       one-cycle completion pulse
// BEHAVIOUR
//  Reset (async, nreset=0): state=IDLE; SRC/DST/LEN=0; done_sticky=0.
//    Outputs dma_req, start, we, dma_irq = 0; address, data = 0.
//  Bus protocol (decided):
//    Initiator drives address/data/we together with start=1 for exactly one cycle.
//    Initiator holds address/data/we stable until completion.
//    Responder raises busy on the cycle after start.
//    Completion = first cycle busy==0 after having been 1; q is valid in that cycle.
//    Never assert start while busy==1.
//  Registers:
//    CTRL write bit0=GO: accepted only in IDLE; copies SRC/DST/LEN into working counters; clears done_sticky.
//    CTRL write bit1=ABORT: honoured in any non-IDLE state; takes effect at the next transaction boundary.
//    SRC/DST/LEN writes while active: shadow registers update; the running copy is unaffected.
//  FSM:
//    IDLE -GO, LEN!=0-> ARB; IDLE -GO, LEN==0-> DONE (no bus traffic).
//    ARB: dma_req=1; waits for dma_gnt=1 && busy=0 -> RD_REQ.
//    RD_REQ: start=1, we=0, address=src -> RD_WAIT.
//    RD_WAIT: on completion latch q into buf -> WR_REQ.
//    WR_REQ: start=1, we=1, address=dst, data=buf -> WR_WAIT.
//    WR_WAIT: on completion: src+=1, dst+=1, cnt-=1.
//      cnt becomes 0 or abort pending -> DONE.
//      dma_gnt=0 -> ARB.
//      otherwise -> RD_REQ.
//    DONE: dma_irq=1 for one cycle; done_sticky=1; dma_req=0 -> IDLE.
//  Grant rules:
//    dma_req stays high from ARB through WR_WAIT.
//    Losing dma_gnt mid-read/write pair does not abort the pair; it is checked only in WR_WAIT and ARB.
//  Arithmetic:
//    src/dst increment modulo 2^ADDR_W (wrap 0x7FFFFFF -> 0, no error).
//    cnt is LEN_W bits; cfg_d bits above LEN_W are ignored.
//  Timing: throughput is 2 bus transactions per word; per-word latency = 2 cycles + 2x responder latency.
// STRUCTURE
//  Shared package (fpgc_bus_pkg): ADDR_W, state enum, CTRL bit indices (GO=0, ABORT=1), cfg register map constants.
//  No sub-module; the register file and FSM sit in one file. Bus completion detect is a one-flop busy_prev edge detector.
// TESTING
//  1. SRC=0x100, DST=0x200, LEN=3, GO; model memory busy=4 cycles
//     -> 6 transactions R100,W200,R101,W201,R102,W202; one dma_irq; CTRL reads 0x1.
//  2. LEN=0, GO -> no start pulse; dma_irq exactly 2 cycles after the CTRL write; done_sticky=1.
//  3. dma_gnt dropped during RD_WAIT of word 1 of 4
//     -> W of word 1 still issued; dma_req held high; resumes at word 2 after regrant.
//  4. ABORT during word 2 of 8 -> word 2 write completes; DST+2.. untouched; cnt=6; dma_irq pulses.
//  5. SRC=0x7FFFFFF, LEN=2 -> reads 0x7FFFFFF then 0x0000000.
//  6. nreset pulsed low mid-WR_WAIT -> all outputs 0 immediately; GO after reset runs cleanly; no spurious irq.

Source files
------------

// File: rtl/fpgc_bus_pkg.sv
// Shared definitions for FPGC4 bus initiators: bus widths, DMA state encoding,
// CTRL bit positions and the DMA configuration register map.
package fpgc_bus_pkg;

  localparam int BUS_ADDR_W = 27;
  localparam int DMA_LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE
  } dma_state_e;

  localparam int CTRL_GO    = 0;
  localparam int CTRL_ABORT = 1;

  localparam logic [1:0] CFG_SRC  = 2'd0;
  localparam logic [1:0] CFG_DST  = 2'd1;
  localparam logic [1:0] CFG_LEN  = 2'd2;
  localparam logic [1:0] CFG_CTRL = 2'd3;

endpackage

// File: rtl/dma_bus_initiator.sv
// Block-copy engine sharing the MemoryUnit bus with the CPU: one read then one write
// per word from SRC to DST, with a one-cycle irq when the copy finishes or is aborted.
//
// state      | meaning
// IDLE       | waiting for GO; shadow registers freely writable
// ARB        | dma_req high, waiting for grant and an idle responder
// RD_REQ     | start pulse, read of src
// RD_WAIT    | waiting for read completion, captures q
// WR_REQ     | start pulse, write of captured word to dst
// WR_WAIT    | waiting for write completion, advances pointers/count
// DONE       | drops dma_req; irq and done flag follow one cycle later
module dma_bus_initiator
  import fpgc_bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int LEN_W  = DMA_LEN_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [31:0]       cfg_d,
  output logic [31:0]       cfg_q,
  output logic              dma_req,
  input  logic              dma_gnt,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data,
  output logic              we,
  output logic              start,
  input  logic              busy,
  input  logic [31:0]       q,
  output logic              dma_irq
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] src_sh_q, dst_sh_q;
  logic [LEN_W-1:0]  len_sh_q;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       data_q, data_d;
  logic              done_q, done_d, abort_q, abort_d, busy_prev_q;
  logic              req_q, req_d, start_q, start_d, we_q, we_d, irq_q, irq_d;
  logic              ctrl_wr, go, abort_req, xfer_done;
  logic              unused_cfg_hi;

  assign unused_cfg_hi = ^cfg_d[31:ADDR_W];

  assign ctrl_wr   = cfg_we && (cfg_addr == CFG_CTRL);
  assign go        = ctrl_wr && cfg_d[CTRL_GO] && (state_q == ST_IDLE);
  assign abort_req = ctrl_wr && cfg_d[CTRL_ABORT] && (state_q != ST_IDLE);
  assign xfer_done = busy_prev_q && !busy;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      src_sh_q <= '0;
      dst_sh_q <= '0;
      len_sh_q <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        CFG_SRC: src_sh_q <= cfg_d[ADDR_W-1:0];
        CFG_DST: dst_sh_q <= cfg_d[ADDR_W-1:0];
        CFG_LEN: len_sh_q <= cfg_d[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_q = '0;
    case (cfg_addr)
      CFG_SRC: cfg_q = 32'(src_sh_q);
      CFG_DST: cfg_q = 32'(dst_sh_q);
      CFG_LEN: cfg_q = 32'(len_sh_q);
      default: cfg_q = {30'd0, state_q != ST_IDLE, done_q};
    endcase
  end

  // Bus outputs are registered and loaded on the edge that enters the state using them.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    abort_d = abort_q | abort_req;
    start_d = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    irq_d   = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (go) begin
          src_d   = src_sh_q;
          dst_d   = dst_sh_q;
          cnt_d   = len_sh_q;
          done_d  = 1'b0;
          state_d = (len_sh_q == '0) ? ST_DONE : ST_ARB;
        end
      end
      ST_ARB: begin
        if (abort_q) begin
          state_d = ST_DONE;
        end else if (dma_gnt && !busy) begin
          state_d = ST_RD_REQ;
          start_d = 1'b1;
          we_d    = 1'b0;
          addr_d  = src_q;
        end
      end
      ST_RD_REQ: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (xfer_done) begin
          data_d  = q;
          state_d = ST_WR_REQ;
          start_d = 1'b1;
          we_d    = 1'b1;
          addr_d  = dst_q;
        end
      end
      ST_WR_REQ: state_d = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (xfer_done) begin
          src_d = src_q + ADDR_W'(1);
          dst_d = dst_q + ADDR_W'(1);
          cnt_d = cnt_q - LEN_W'(1);
          if ((cnt_q == LEN_W'(1)) || abort_d) begin
            state_d = ST_DONE;
          end else if (!dma_gnt) begin
            state_d = ST_ARB;
          end else begin
            state_d = ST_RD_REQ;
            start_d = 1'b1;
            we_d    = 1'b0;
            addr_d  = src_d;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        abort_d = 1'b0;
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      busy_prev_q <= 1'b0;
      req_q       <= 1'b0;
      start_q     <= 1'b0;
      we_q        <= 1'b0;
      irq_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      busy_prev_q <= busy;
      req_q       <= req_d;
      start_q     <= start_d;
      we_q        <= we_d;
      irq_q       <= irq_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign dma_req = req_q;
  assign start   = start_q;
  assign we      = we_q;
  assign dma_irq = irq_q;
  assign address = addr_q;
  assign data    = data_q;

endmodule

// File: tb/tb_dma_bus_initiator.sv
// Bench for dma_bus_initiator: responder memory with variable latency, expected
// transaction lists computed from the copy rules, directed and randomized copies.
module tb_dma_bus_initiator;
  import fpgc_bus_pkg::*;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_d = '0;
  logic [31:0] cfg_q;
  logic        dma_req, dma_gnt, we, start, dma_irq;
  logic        gnt_man = 1'b1, gnt_rnd = 1'b1;
  logic [26:0] address;
  logic [31:0] data;
  logic        busy = 1'b0;
  logic [31:0] q = '0;

  assign dma_gnt = gnt_man & gnt_rnd;

  dma_bus_initiator dut (
    .clk(clk), .nreset(nreset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_d(cfg_d),
    .cfg_q(cfg_q), .dma_req(dma_req), .dma_gnt(dma_gnt), .address(address), .data(data),
    .we(we), .start(start), .busy(busy), .q(q), .dma_irq(dma_irq)
  );

  always #10 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0, irq_cnt = 0, irq_cyc = 0, start_cnt = 0, wr_cyc = 0;
  int irq0 = 0, start0 = 0;
  int lat_min = 4, lat_max = 4;
  bit rand_gnt = 1'b0;

  typedef struct {logic w; logic [26:0] a; logic [31:0] d;} txn_t;
  txn_t        log_q[$];
  logic [31:0] mem [logic [26:0]];
  logic [26:0] r_addr = '0;
  logic        r_we = 1'b0;
  logic [31:0] r_data = '0;
  int          r_cnt = 0;

  logic [26:0] exp_src, exp_dst;
  logic [31:0] exp_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_val(input logic [26:0] a);
    if (mem.exists(a)) return mem[a];
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dma_irq) begin
      irq_cnt++;
      irq_cyc = cyc;
    end
    if (start) start_cnt++;
  end

  always @(negedge clk) gnt_rnd = rand_gnt ? ($urandom_range(3, 0) != 0) : 1'b1;

  // Responder: busy from the cycle after start for r_cnt cycles; q valid when busy falls.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      busy  <= 1'b0;
      r_cnt = 0;
    end else if (busy) begin
      check("no_start_while_busy", 32'(start), 32'd0);
      if (r_cnt <= 1) begin
        check("addr_held", {4'd0, we, address}, {4'd0, r_we, r_addr});
        busy <= 1'b0;
        if (r_we) mem[r_addr] = r_data;
        else q <= rd_val(r_addr);
      end else begin
        r_cnt--;
      end
    end else if (start) begin
      r_addr = address;
      r_we   = we;
      r_data = data;
      r_cnt  = $urandom_range(lat_max, lat_min);
      busy   <= 1'b1;
      log_q.push_back('{we, address, data});
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_d = d; wr_cyc = cyc;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    cfg_addr = a;
    #1 v = cfg_q;
  endtask

  task automatic start_copy(input logic [26:0] s, input logic [26:0] d,
                            input logic [31:0] len_word, input int n);
    exp_src = s;
    exp_dst = d;
    exp_data.delete();
    for (int i = 0; i < n; i++) exp_data.push_back(rd_val(s + 27'(i)));
    log_q.delete();
    irq0   = irq_cnt;
    start0 = start_cnt;
    cfg_write(CFG_SRC, 32'(s));
    cfg_write(CFG_DST, 32'(d));
    cfg_write(CFG_LEN, len_word);
    cfg_write(CFG_CTRL, 32'h1);
  endtask

  task automatic wait_irq(input string tag, input int budget);
    int k = 0;
    while (irq_cnt == irq0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_irq_seen"}, 32'(irq_cnt > irq0), 32'd1);
    repeat (3) @(negedge clk);
    check({tag, "_irq_once"}, 32'(irq_cnt - irq0), 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_log_reached"}, 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic check_log(input string tag, input int n);
    check({tag, "_ntxn"}, 32'(log_q.size()), 32'(2 * n));
    for (int i = 0; i < n; i++) begin
      if (2 * i + 1 < log_q.size()) begin
        check({tag, "_rd"}, {4'd0, log_q[2*i].w, log_q[2*i].a}, {5'd0, exp_src + 27'(i)});
        check({tag, "_wr"}, {4'd0, log_q[2*i+1].w, log_q[2*i+1].a}, {4'd0, 1'b1, exp_dst + 27'(i)});
        check({tag, "_wdata"}, log_q[2*i+1].d, exp_data[i]);
      end
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: run did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;

    repeat (3) @(negedge clk);
    check("rst_ctl_outs", {28'd0, dma_req, start, we, dma_irq}, 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_data", data, 32'd0);
    nreset = 1'b1;
    cfg_read(CFG_SRC, v);  check("rst_src", v, 32'd0);
    cfg_read(CFG_LEN, v);  check("rst_len", v, 32'd0);
    cfg_read(CFG_CTRL, v); check("rst_ctrl", v, 32'd0);

    // basic three-word copy, responder latency 4
    lat_min = 4; lat_max = 4;
    start_copy(27'h100, 27'h200, 32'd3, 3);
    wait_irq("t1", 400);
    check_log("t1", 3);
    cfg_read(CFG_CTRL, v); check("t1_ctrl", v, 32'h1);
    cfg_read(CFG_LEN, v);  check("t1_len_rb", v, 32'd3);

    // zero length: no bus traffic, irq two cycles after GO write
    start_copy(27'h10, 27'h20, 32'd0, 0);
    wait_irq("t2", 50);
    check("t2_irq_latency", 32'(irq_cyc - wr_cyc), 32'd2);
    check("t2_no_start", 32'(start_cnt - start0), 32'd0);
    cfg_read(CFG_CTRL, v); check("t2_ctrl", v, 32'h1);

    // grant dropped during the first read; shadow SRC rewritten while stalled
    lat_min = 3; lat_max = 3;
    start_copy(27'h400, 27'h500, 32'd4, 4);
    wait_log("t3", 1, 100);
    @(negedge clk);
    gnt_man = 1'b0;
    cfg_write(CFG_SRC, 32'h999);
    repeat (40) @(negedge clk);
    check("t3_stalled_ntxn", 32'(log_q.size()), 32'd2);
    check("t3_req_held", 32'(dma_req), 32'd1);
    cfg_read(CFG_CTRL, v); check("t3_ctrl_active", v, 32'h2);
    cfg_read(CFG_SRC, v);  check("t3_src_shadow", v, 32'h999);
    gnt_man = 1'b1;
    wait_irq("t3", 400);
    check_log("t3", 4);

    // abort while word 2 of 8 is being read
    lat_min = 2; lat_max = 2;
    start_copy(27'h600, 27'h700, 32'd8, 8);
    wait_log("t4", 3, 200);
    cfg_write(CFG_CTRL, 32'h2);
    wait_irq("t4", 400);
    check_log("t4", 2);
    check("t4_dst2_untouched", 32'(mem.exists(27'h702)), 32'd0);
    check("t4_dst7_untouched", 32'(mem.exists(27'h707)), 32'd0);
    cfg_read(CFG_CTRL, v); check("t4_ctrl", v, 32'h1);

    // source address wrap; upper LEN bits ignored
    lat_min = 1; lat_max = 1;
    start_copy(27'h7FF_FFFF, 27'h800, 32'hABCD_0002, 2);
    wait_irq("t5", 200);
    check_log("t5", 2);
    cfg_read(CFG_LEN, v); check("t5_len_rb", v, 32'd2);

    // randomized copies: random latency, random grant loss
    rand_gnt = 1'b1;
    lat_min = 1; lat_max = 5;
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(6, 1);
      start_copy(27'h1000 + 27'(it * 64) + 27'($urandom_range(15, 0)),
                 27'h4000 + 27'(it * 64) + 27'($urandom_range(15, 0)), 32'(n), n);
      wait_irq("rnd", 2000);
      check_log("rnd", n);
    end
    rand_gnt = 1'b0;

    // reset in the middle of a write
    lat_min = 4; lat_max = 4;
    start_copy(27'h900, 27'hA00, 32'd4, 4);
    wait_log("t6", 2, 200);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    check("t6_rst_ctl_outs", {28'd0, dma_req, start, we, dma_irq}, 32'd0);
    check("t6_rst_address", 32'(address), 32'd0);
    check("t6_rst_data", data, 32'd0);
    cfg_read(CFG_CTRL, v); check("t6_rst_ctrl", v, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    irq0 = irq_cnt;
    repeat (10) @(negedge clk);
    check("t6_no_spurious_irq", 32'(irq_cnt - irq0), 32'd0);
    start_copy(27'hB00, 27'hC00, 32'd3, 3);
    wait_irq("t6", 400);
    check_log("t6", 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
